// File: rtl/seq_det_pkg.sv
// Shared types and reset constants for the parameterised sequence detector.
package seq_det_pkg;

    // Moore states: still collecting bits, enough bits but no match, match seen
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HUNT  = 2'd1,
        MATCH = 2'd2
    } state_t;

    // Configuration loaded by reset: overlapping detection of 1011
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         DEF_LEN     = 4;
    localparam logic       DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with a sticky saturation flag and synchronous clear.
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_sat
);

    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic [CNT_W-1:0] w_next;

    assign w_next = r_count + CNT_W'(1);

    // Clear has priority over an increment in the same cycle; hold at all-ones
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (i_clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (i_inc && !(&r_count)) begin
            r_count <= w_next;
            if (&w_next)
                r_sat <= 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_sat   = r_sat;

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-configurable serial pattern detector (Moore, 1-cycle latency) with
// overlap / non-overlap modes and a saturating match counter.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic               cfg_err
);

    state_t             r_state, w_state_n;
    logic [MAX_LEN-1:0] r_pat, w_pat_n;
    logic [LEN_W-1:0]   r_len, w_len_n;
    logic               r_ovl, w_ovl_n;
    logic [MAX_LEN-1:0] r_hist, w_hist_n;
    logic [LEN_W-1:0]   r_fill, w_fill_n;
    logic               r_err, w_err_n;

    logic [MAX_LEN-1:0] w_hist_sh;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;
    logic               w_inc;
    logic               w_cfg_ok;

    // Low r_len bits of the history take part in the comparison
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            w_mask[i] = (LEN_W'(i) < r_len);
    end

    assign w_hist_sh  = {r_hist[MAX_LEN-2:0], sequence_in};
    assign w_fill_inc = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
    assign w_cfg_ok   = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));

    // Next-state: cfg_load takes the cycle (bit discarded), else accept a valid bit
    always_comb begin
        w_state_n = r_state;
        w_pat_n   = r_pat;
        w_len_n   = r_len;
        w_ovl_n   = r_ovl;
        w_hist_n  = r_hist;
        w_fill_n  = r_fill;
        w_err_n   = 1'b0;
        w_match   = 1'b0;
        w_inc     = 1'b0;
        if (cfg_load) begin
            if (w_cfg_ok) begin
                w_pat_n   = cfg_pattern;
                w_len_n   = cfg_len;
                w_ovl_n   = cfg_overlap;
                w_hist_n  = '0;
                w_fill_n  = '0;
                w_state_n = FILL;
            end else begin
                w_err_n = 1'b1;
            end
        end else if (in_valid) begin
            w_hist_n = w_hist_sh;
            w_fill_n = w_fill_inc;
            w_match  = (w_fill_inc >= r_len) && (((w_hist_sh ^ r_pat) & w_mask) == '0);
            if (w_match) begin
                w_state_n = MATCH;
                w_inc     = 1'b1;
                // Non-overlap: the next match must be built from fresh bits
                if (!r_ovl)
                    w_fill_n = '0;
            end else if (w_fill_inc >= r_len) begin
                w_state_n = HUNT;
            end else begin
                w_state_n = FILL;
            end
        end
    end

    // State, configuration and history registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= FILL;
            r_pat   <= MAX_LEN'(DEF_PATTERN);
            r_len   <= LEN_W'(DEF_LEN);
            r_ovl   <= DEF_OVERLAP;
            r_hist  <= '0;
            r_fill  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pat   <= w_pat_n;
            r_len   <= w_len_n;
            r_ovl   <= w_ovl_n;
            r_hist  <= w_hist_n;
            r_fill  <= w_fill_n;
            r_err   <= w_err_n;
        end
    end

    seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_inc   (w_inc),
        .i_clr   (count_clr),
        .o_count (match_count),
        .o_sat   (count_sat)
    );

    assign detector_out = (r_state == MATCH);
    assign cfg_err      = r_err;

endmodule

// File: tb/tb_param_seq_detector.sv
// Randomised and directed bench for param_seq_detector. Two instances share the
// stimulus: default CNT_W=8 and CNT_W=2 (for saturation). A queue-based model
// of accepted bits predicts every output.
module tb_param_seq_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic clock = 1'b0, reset = 1'b0;
    logic sequence_in = 1'b0, in_valid = 1'b0, cfg_load = 1'b0;
    logic cfg_overlap = 1'b0, count_clr = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;

    logic       det_a, sat_a, err_a, det_b, sat_b, err_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    param_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clr(count_clr), .detector_out(det_a),
        .match_count(cnt_a), .count_sat(sat_a), .cfg_err(err_a));

    param_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clr(count_clr), .detector_out(det_b),
        .match_count(cnt_b), .count_sat(sat_b), .cfg_err(err_b));

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: the active pattern, and the bits accepted since the
    // last restart point (reset, legal cfg_load, or a non-overlap match)
    logic [MAX_LEN-1:0] m_pat;
    int   m_len;
    bit   m_ovl;
    bit   q[$];
    bit   m_det, m_err, m_sat8, m_sat2;
    int   m_cnt8, m_cnt2;

    function automatic void model_reset();
        m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
        q.delete();
        m_det = 0; m_err = 0; m_sat8 = 0; m_sat2 = 0; m_cnt8 = 0; m_cnt2 = 0;
    endfunction

    function automatic void model_edge();
        bit hit;
        m_err = 0;
        if (cfg_load) begin
            if (cfg_len >= 2 && cfg_len <= MAX_LEN) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
                q.delete(); m_det = 0;
            end else
                m_err = 1;
        end else if (in_valid) begin
            q.push_back(sequence_in);
            hit = (q.size() >= m_len);
            if (hit)
                for (int i = 0; i < m_len; i++)
                    if (q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 0;
            m_det = hit;
            if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt8 == 255) m_sat8 = 1;
                if (m_cnt2 < 3) m_cnt2++;
                if (m_cnt2 == 3) m_sat2 = 1;
                if (!m_ovl) q.delete();
            end
            if (q.size() > 32) void'(q.pop_front());
        end
        if (count_clr) begin
            m_cnt8 = 0; m_sat8 = 0; m_cnt2 = 0; m_sat2 = 0;
        end
    endfunction

    function automatic logic [15:0] obs();
        return {det_a, cnt_a, sat_a, err_a, det_b, cnt_b, sat_b, err_b};
    endfunction

    function automatic logic [15:0] expv();
        return {m_det, 8'(m_cnt8), m_sat8, m_err, m_det, 2'(m_cnt2), m_sat2, m_err};
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, settle for sampling
    task automatic step(input logic v, input logic b, input logic ld = 0, input logic clr = 0);
        in_valid = v; sequence_in = b; cfg_load = ld; count_clr = clr;
        @(posedge clock);
        model_edge();
        #1;
        in_valid = 0; cfg_load = 0; count_clr = 0;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input int len, input logic ovl);
        cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
        step(0, 0, 1);
    endtask

    task automatic test_reset();
        #2 reset = 1;
        #1;
        model_reset();
        n_cmp++;
        if (obs() !== 16'h0) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", obs(), 16'h0);
        end
        repeat (2) @(posedge clock);
        #1 reset = 0;
    endtask

    task automatic test_default_1011();
        logic [6:0] bits;
        logic [6:0] want;
        bits = 7'b1011011;
        want = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            step(1, bits[i]);
            n_cmp++;
            if (det_a !== want[i] || obs() !== expv()) begin
                n_bad++; $display("FAIL default_1011 bit%0d: got %h want det=%b vec %h", 6 - i, obs(), want[i], expv());
            end
        end
        n_cmp++;
        if (cnt_a !== 8'd2) begin
            n_bad++; $display("FAIL default_count: got %0d want 2", cnt_a);
        end
    endtask

    task automatic run_ones(input logic ovl, input logic [5:0] want, input int want_cnt);
        load_cfg(8'b111, 3, ovl);
        step(0, 0, 0, 1);
        for (int i = 5; i >= 0; i--) begin
            step(1, 1);
            n_cmp++;
            if (det_a !== want[i] || obs() !== expv()) begin
                n_bad++; $display("FAIL ones_ovl%0d bit%0d: got %h want det=%b vec %h", ovl, 6 - i, obs(), want[i], expv());
            end
        end
        n_cmp++;
        if (cnt_a !== 8'(want_cnt)) begin
            n_bad++; $display("FAIL ones_ovl%0d_count: got %0d want %0d", ovl, cnt_a, want_cnt);
        end
    endtask

    task automatic test_overlap_modes();
        run_ones(0, 6'b001001, 2);
        run_ones(1, 6'b001111, 4);
    endtask

    task automatic test_gap();
        load_cfg(8'b1011, 4, 1);
        step(1, 1); step(1, 0); step(1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1);
            n_cmp++;
            if (det_a !== 1'b0 || obs() !== expv()) begin
                n_bad++; $display("FAIL gap cycle%0d: got %h want %h", i, obs(), expv());
            end
        end
        step(1, 1);
        n_cmp++;
        if (det_a !== 1'b1 || obs() !== expv()) begin
            n_bad++; $display("FAIL gap_final: got %h want det=1 vec %h", obs(), expv());
        end
    endtask

    task automatic test_cfg_err();
        int bad_len[2];
        bad_len[0] = 1; bad_len[1] = MAX_LEN + 1;
        for (int k = 0; k < 2; k++) begin
            load_cfg(8'b1, bad_len[k], 0);
            n_cmp++;
            if (err_a !== 1'b1 || obs() !== expv()) begin
                n_bad++; $display("FAIL cfg_err len%0d: got %h want err=1 vec %h", bad_len[k], obs(), expv());
            end
            step(0, 0);
            n_cmp++;
            if (err_a !== 1'b0) begin
                n_bad++; $display("FAIL cfg_err_pulse len%0d: got %b want 0", bad_len[k], err_a);
            end
        end
        step(1, 1); step(1, 0); step(1, 1); step(1, 1);
        n_cmp++;
        if (det_a !== 1'b1 || obs() !== expv()) begin
            n_bad++; $display("FAIL after_err_1011: got %h want det=1 vec %h", obs(), expv());
        end
    endtask

    task automatic test_saturation();
        logic [15:0] bits;
        bits = 16'b1011_0110_1101_1011;
        step(0, 0, 0, 1);
        for (int i = 15; i >= 0; i--) step(1, bits[i]);
        n_cmp++;
        if (cnt_b !== 2'd3 || sat_b !== 1'b1 || cnt_a !== 8'd5 || sat_a !== 1'b0) begin
            n_bad++; $display("FAIL saturate: got cnt2=%0d sat2=%b cnt8=%0d sat8=%b want 3 1 5 0", cnt_b, sat_b, cnt_a, sat_a);
        end
        step(1, 0); step(1, 1); step(1, 1, 0, 1);
        n_cmp++;
        if (det_a !== 1'b1 || cnt_a !== 8'd0 || cnt_b !== 2'd0 || sat_b !== 1'b0) begin
            n_bad++; $display("FAIL clr_wins: got det=%b cnt8=%0d cnt2=%0d sat2=%b want 1 0 0 0", det_a, cnt_a, cnt_b, sat_b);
        end
    endtask

    task automatic test_async_reset();
        step(1, 1); step(1, 0); step(1, 1); step(1, 1);
        #2 reset = 1;
        #1 model_reset();
        n_cmp++;
        if (det_a !== 1'b0 || cnt_a !== 8'd0) begin
            n_bad++; $display("FAIL async_reset_match: got det=%b cnt=%0d want 0 0", det_a, cnt_a);
        end
        @(posedge clock); #1 reset = 0;
        step(1, 1); step(1, 0); step(1, 1);
        #2 reset = 1;
        #1 model_reset();
        n_cmp++;
        if (obs() !== 16'h0) begin
            n_bad++; $display("FAIL async_reset_mid: got %h want 0000", obs());
        end
        @(posedge clock); #1 reset = 0;
        step(1, 1);
        n_cmp++;
        if (det_a !== 1'b0 || obs() !== expv()) begin
            n_bad++; $display("FAIL lone_one: got %h want det=0 vec %h", obs(), expv());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) < 4) begin
                cfg_pattern = 8'($urandom);
                cfg_len     = LEN_W'($urandom_range(0, 10) < 8 ? $urandom_range(2, 4) : $urandom_range(0, 10));
                cfg_overlap = 1'($urandom);
                step(1'($urandom), 1'($urandom), 1, 0);
            end else begin
                step($urandom_range(0, 9) < 7, 1'($urandom), 0, $urandom_range(0, 99) < 3);
            end
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL random cycle%0d: got %h want %h", c, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_1011();
        test_overlap_modes();
        test_gap();
        test_cfg_err();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
